// File: rtl/hub75_rx_capture.sv
// hub75_rx_capture
// Receives a HUB75-style panel stream (bit clock, latch, row-pair address,
// serial top/bottom RGB), oversampled on clk_in. Each latched row pair is
// written out pixel by pixel (top row, then bottom row) over a valid/ready
// port into a frame buffer.
//
// Ports:
//   clk_in, n_reset_in       system clock, async active-low reset
//   bit_clk_in               panel bit clock (async)
//   latch_enable_in          panel latch, active high (async)
//   addr_in                  panel row-pair address (async)
//   rgb_top_in, rgb_bot_in   serial {R,G,B} for top / bottom half (async)
//   pxl_valid_out/ready_in   pixel write handshake
//   pxl_addr_out             row*NUM_COLS + col
//   pxl_rgb_out              pixel colour
//   row_done_out             pulse after the last pixel of a row pair is accepted
//   overrun_out              pulse when a latch is dropped (write-out busy)
//   length_err_out           sticky: latch seen with bit count != NUM_COLS
//
// Handshake: a write transfers on a cycle where pxl_valid_out && pxl_ready_in.
// While pxl_valid_out is high and pxl_ready_in low, valid, address and colour
// hold their values; they are decoded only from flops (state, col, buffers).

module hub75_rx_capture #(
  parameter int NUM_ROWS   = 32,
  parameter int NUM_COLS   = 64,
  parameter int ROW_ADDR_W = $clog2(NUM_ROWS/2),
  parameter int PXL_ADDR_W = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  bit_clk_in,
  input  logic                  latch_enable_in,
  input  logic [ROW_ADDR_W-1:0] addr_in,
  input  logic [2:0]            rgb_top_in,
  input  logic [2:0]            rgb_bot_in,
  output logic                  pxl_valid_out,
  input  logic                  pxl_ready_in,
  output logic [PXL_ADDR_W-1:0] pxl_addr_out,
  output logic [2:0]            pxl_rgb_out,
  output logic                  row_done_out,
  output logic                  overrun_out,
  output logic                  length_err_out
);

  localparam int CNT_W = $clog2(NUM_COLS + 2);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int SR_W  = 3 * NUM_COLS;

  typedef enum logic [1:0] {IDLE, WR_TOP, WR_BOT, DONE} state_t;

  state_t state_q, state_d;

  // Synchronizers: every panel input sees the same two-stage depth so data
  // sampled at a detected bit-clock rise is the data present at the panel edge.
  logic                  bclk_s1, bclk_s2, bclk_s3;
  logic                  le_s1, le_s2, le_s3;
  logic [ROW_ADDR_W-1:0] addr_s1, addr_s2;
  logic [2:0]            top_s1, top_s2, bot_s1, bot_s2;

  logic [SR_W-1:0]       top_sr, bot_sr, top_buf, bot_buf;
  logic [SR_W-1:0]       top_shifted, bot_shifted;
  logic [CNT_W-1:0]      bit_cnt, cnt_next;
  logic [COL_W-1:0]      col;
  logic [ROW_ADDR_W-1:0] row_addr;
  logic [PXL_ADDR_W-1:0] row_sel;
  logic                  bclk_rise, le_rise, latch_take, col_last, accept;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      bclk_s1 <= 1'b0; bclk_s2 <= 1'b0; bclk_s3 <= 1'b0;
      le_s1   <= 1'b0; le_s2   <= 1'b0; le_s3   <= 1'b0;
      addr_s1 <= '0;   addr_s2 <= '0;
      top_s1  <= '0;   top_s2  <= '0;
      bot_s1  <= '0;   bot_s2  <= '0;
    end else begin
      bclk_s1 <= bit_clk_in;      bclk_s2 <= bclk_s1; bclk_s3 <= bclk_s2;
      le_s1   <= latch_enable_in; le_s2   <= le_s1;   le_s3   <= le_s2;
      addr_s1 <= addr_in;         addr_s2 <= addr_s1;
      top_s1  <= rgb_top_in;      top_s2  <= top_s1;
      bot_s1  <= rgb_bot_in;      bot_s2  <= bot_s1;
    end
  end

  assign bclk_rise  = bclk_s2 & ~bclk_s3;
  assign le_rise    = le_s2 & ~le_s3;
  assign latch_take = le_rise && (state_q == IDLE);
  assign col_last   = (col == COL_W'(NUM_COLS - 1));
  assign accept     = pxl_valid_out && pxl_ready_in;

  // Shift first, latch second: a latch in the same cycle as a bit-clock rise
  // captures the post-shift registers and judges the post-increment count.
  // Newest bit enters column 0, so the first of NUM_COLS bits ends in the top
  // column, as in a physical shift chain.
  always_comb begin
    top_shifted = top_sr;
    bot_shifted = bot_sr;
    cnt_next    = bit_cnt;
    if (bclk_rise) begin
      top_shifted = {top_sr[SR_W-4:0], top_s2};
      bot_shifted = {bot_sr[SR_W-4:0], bot_s2};
      if (bit_cnt != CNT_W'(NUM_COLS + 1)) cnt_next = bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      top_sr         <= '0;
      bot_sr         <= '0;
      top_buf        <= '0;
      bot_buf        <= '0;
      bit_cnt        <= '0;
      row_addr       <= '0;
      col            <= '0;
      overrun_out    <= 1'b0;
      length_err_out <= 1'b0;
    end else begin
      top_sr      <= top_shifted;
      bot_sr      <= bot_shifted;
      bit_cnt     <= le_rise ? '0 : cnt_next;
      overrun_out <= le_rise && (state_q != IDLE);
      if (le_rise && (cnt_next != CNT_W'(NUM_COLS))) length_err_out <= 1'b1;
      if (latch_take) begin
        top_buf  <= top_shifted;
        bot_buf  <= bot_shifted;
        row_addr <= addr_s2;
        col      <= '0;
      end else if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (latch_take)                     state_d = WR_TOP;
      WR_TOP:  if (pxl_ready_in && col_last)       state_d = WR_BOT;
      WR_BOT:  if (pxl_ready_in && col_last)       state_d = DONE;
      DONE:                                        state_d = IDLE;
      default:                                     state_d = IDLE;
    endcase
  end

  // FSM: outputs. Bottom half of the panel sits NUM_ROWS/2 rows below.
  always_comb begin
    pxl_valid_out = 1'b0;
    pxl_addr_out  = '0;
    pxl_rgb_out   = '0;
    row_done_out  = 1'b0;
    row_sel       = PXL_ADDR_W'(row_addr);
    case (state_q)
      WR_TOP: begin
        pxl_valid_out = 1'b1;
        pxl_addr_out  = row_sel * PXL_ADDR_W'(NUM_COLS) + PXL_ADDR_W'(col);
        pxl_rgb_out   = top_buf[int'(col)*3 +: 3];
      end
      WR_BOT: begin
        row_sel       = PXL_ADDR_W'(row_addr) + PXL_ADDR_W'(NUM_ROWS/2);
        pxl_valid_out = 1'b1;
        pxl_addr_out  = row_sel * PXL_ADDR_W'(NUM_COLS) + PXL_ADDR_W'(col);
        pxl_rgb_out   = bot_buf[int'(col)*3 +: 3];
      end
      DONE:    row_done_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hub75_rx_capture.sv
module tb_hub75_rx_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset, bit_clk, le, ready;
  logic [3:0]  addr;
  logic [2:0]  rgb_top, rgb_bot;
  logic        valid, row_done, overrun, len_err;
  logic [10:0] pxl_addr;
  logic [2:0]  pxl_rgb;

  hub75_rx_capture dut (
    .clk_in          (clk),
    .n_reset_in      (n_reset),
    .bit_clk_in      (bit_clk),
    .latch_enable_in (le),
    .addr_in         (addr),
    .rgb_top_in      (rgb_top),
    .rgb_bot_in      (rgb_bot),
    .pxl_valid_out   (valid),
    .pxl_ready_in    (ready),
    .pxl_addr_out    (pxl_addr),
    .pxl_rgb_out     (pxl_rgb),
    .row_done_out    (row_done),
    .overrun_out     (overrun),
    .length_err_out  (len_err)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          passes = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_e;
  int          wr_cnt = 0, done_cnt = 0, ovr_cnt = 0;
  bit          mon_en = 0, rand_ready = 0;
  bit          written[2048];
  logic [2:0]  send_top[128], send_bot[128];
  logic [2:0]  col_top[64], col_bot[64];
  logic        prev_stall = 1'b0;
  logic [10:0] prev_addr;
  logic [2:0]  prev_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (row_done) done_cnt++;
    if (overrun)  ovr_cnt++;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(valid), 1);
        check("stall_addr", 32'(pxl_addr), 32'(prev_addr));
        check("stall_rgb", 32'(pxl_rgb), 32'(prev_rgb));
      end
      prev_stall = 1'b0;
      if (valid && ready) begin
        wr_cnt++;
        written[pxl_addr] = 1'b1;
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 32'(pxl_addr), 32'(exp_e[13:3]));
          check("wr_rgb", 32'(pxl_rgb), 32'(exp_e[2:0]));
        end
      end else if (valid) begin
        prev_stall = 1'b1;
        prev_addr  = pxl_addr;
        prev_rgb   = pxl_rgb;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      rgb_top = send_top[i];
      rgb_bot = send_bot[i];
      cycles(4);
      bit_clk = 1'b1;
      cycles(4);
      bit_clk = 1'b0;
    end
  endtask

  task automatic latch(input logic [3:0] a);
    addr = a;
    cycles(4);
    le = 1'b1;
    cycles(4);
    le = 1'b0;
    cycles(1);
  endtask

  task automatic push_row(input int a);
    for (int c = 0; c < 64; c++) exp_q.push_back({11'(a*64 + c), col_top[c]});
    for (int c = 0; c < 64; c++) exp_q.push_back({11'((a+16)*64 + c), col_bot[c]});
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      cycles(1);
      n++;
    end
    check("row_done_cnt", 32'(done_cnt), 32'(target));
    check("exp_q_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic fill_index_row();
    int c;
    for (int i = 0; i < 64; i++) begin
      c = 63 - i;
      send_top[i] = {3{c[0]}};
      send_bot[i] = 3'b101;
    end
    for (int k = 0; k < 64; k++) begin
      c = k;
      col_top[k] = {3{c[0]}};
      col_bot[k] = 3'b101;
    end
  endtask

  task automatic fill_const(input logic [2:0] t, input logic [2:0] b);
    for (int i = 0; i < 128; i++) begin
      send_top[i] = t;
      send_bot[i] = b;
    end
    for (int k = 0; k < 64; k++) begin
      col_top[k] = t;
      col_bot[k] = b;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr0, vcnt, lat, wn;

    // Reset with random panel activity
    n_reset = 1'b0; ready = 1'b0;
    bit_clk = 1'b0; le = 1'b0; addr = '0; rgb_top = '0; rgb_bot = '0;
    repeat (10) begin
      @(posedge clk); #1;
      bit_clk = 1'($urandom_range(0, 1));
      le      = 1'($urandom_range(0, 1));
      addr    = 4'($urandom_range(0, 15));
      rgb_top = 3'($urandom_range(0, 7));
      rgb_bot = 3'($urandom_range(0, 7));
    end
    check("rst_valid", 32'(valid), 0);
    check("rst_addr", 32'(pxl_addr), 0);
    check("rst_rgb", 32'(pxl_rgb), 0);
    check("rst_row_done", 32'(row_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_len_err", 32'(len_err), 0);
    bit_clk = 1'b0; le = 1'b0; addr = '0; rgb_top = '0; rgb_bot = '0;
    cycles(3);
    n_reset = 1'b1;
    vcnt = 0;
    repeat (50) begin cycles(1); if (valid) vcnt++; end
    check("rst_no_valid", 32'(vcnt), 0);
    done_cnt = 0; ovr_cnt = 0;
    mon_en = 1'b1;
    ready  = 1'b1;

    // Single row, addr 3, with latch-to-first-valid latency
    fill_index_row();
    push_row(3);
    wr0 = wr_cnt;
    shift_bits(64);
    addr = 4'h3;
    cycles(4);
    le = 1'b1;
    lat = 0;
    while (!valid && lat < 20) begin cycles(1); lat++; end
    check("le_to_valid", 32'(lat), 3);
    le = 1'b0;
    wait_done(1, 400);
    check("single_wr_cnt", 32'(wr_cnt - wr0), 128);
    check("single_overrun", 32'(ovr_cnt), 0);
    check("single_len_err", 32'(len_err), 0);

    // Backpressure: same row, random ready
    push_row(3);
    wr0 = wr_cnt;
    shift_bits(64);
    rand_ready = 1'b1;
    latch(4'h3);
    wait_done(2, 2000);
    rand_ready = 1'b0;
    cycles(1);
    ready = 1'b1;
    check("bp_wr_cnt", 32'(wr_cnt - wr0), 128);

    // Overrun: second latch while first row is stalled
    ready = 1'b0;
    push_row(5);
    wr0 = wr_cnt;
    shift_bits(64);
    latch(4'h5);
    fill_const(3'b111, 3'b111);
    shift_bits(64);
    latch(4'h6);
    cycles(5);
    check("ovr_pulses", 32'(ovr_cnt), 1);
    check("ovr_hold_valid", 32'(valid), 1);
    check("ovr_hold_addr", 32'(pxl_addr), 320);
    ready = 1'b1;
    wait_done(3, 400);
    cycles(200);
    check("ovr_wr_cnt", 32'(wr_cnt - wr0), 128);
    check("ovr_no_second_row", 32'(done_cnt), 3);

    // Full frame of colour 111 on all 16 row pairs
    for (int i = 0; i < 2048; i++) written[i] = 1'b0;
    fill_const(3'b111, 3'b111);
    wr0 = wr_cnt;
    for (int r = 0; r < 16; r++) begin
      push_row(r);
      shift_bits(64);
      latch(4'(r));
      wait_done(4 + r, 400);
    end
    wn = 0;
    for (int i = 0; i < 2048; i++) if (written[i]) wn++;
    check("frame_unique_addr", 32'(wn), 2048);
    check("frame_wr_cnt", 32'(wr_cnt - wr0), 2048);
    check("frame_overrun", 32'(ovr_cnt), 1);
    check("frame_len_err", 32'(len_err), 0);

    // 63 bits: column 63 keeps the previous row's column-0 value (111)
    fill_const(3'b010, 3'b001);
    col_top[63] = 3'b111;
    col_bot[63] = 3'b111;
    push_row(2);
    wr0 = wr_cnt;
    shift_bits(63);
    latch(4'h2);
    wait_done(20, 400);
    check("len63_wr_cnt", 32'(wr_cnt - wr0), 128);
    check("len63_err", 32'(len_err), 1);
    cycles(20);
    check("len63_err_sticky", 32'(len_err), 1);

    // Reset mid-write: write-out abandoned, error flag cleared
    fill_const(3'b111, 3'b111);
    shift_bits(64);
    mon_en = 1'b0;
    latch(4'h7);
    cycles(10);
    n_reset = 1'b0;
    cycles(2);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_len_err", 32'(len_err), 0);
    n_reset = 1'b1;
    vcnt = 0;
    repeat (50) begin cycles(1); if (valid) vcnt++; end
    check("midrst_no_valid", 32'(vcnt), 0);
    check("midrst_no_done", 32'(done_cnt), 20);
    mon_en = 1'b1;

    // 65 bits: oldest bit falls off, all columns carry the new colour
    fill_const(3'b100, 3'b011);
    push_row(9);
    wr0 = wr_cnt;
    shift_bits(65);
    latch(4'h9);
    wait_done(21, 400);
    check("len65_wr_cnt", 32'(wr_cnt - wr0), 128);
    check("len65_err", 32'(len_err), 1);
    check("len65_overrun", 32'(ovr_cnt), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
